rv_retire_fifo: RTL

Buffers one record per retired instruction from the core's writeback stage and drains records through a valid/ready stream to a trace sink (debug UART, trace RAM, or host bridge). It sits directly downstream of writeback, in parallel with the simulation trace printer, and gives synthesizable designs the same per-instruction information. On overflow, whole records are dropped and counted. When space frees, a single DROP marker record carrying the count is inserted, so the sink always knows where the gap is.

---
 rtl/rv_retire_fifo.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rv_retire_fifo.sv
// rv_retire_fifo
// ---------------------------------------------------------------------------
// Buffers one record per retired instruction and drains the records through a
// valid/ready stream to a trace sink. If the buffer overflows, whole records
// are discarded and counted. Once space frees up, a single DROP marker record
// carrying that count is inserted, so the sink can see exactly where the gap
// in the trace is.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_flush                 synchronous clear (same effect as reset)
//   i_retire_*              retiring instruction: pc, instr, rd write,
//                           memory access
//   o_rec_valid/i_rec_ready head-of-queue handshake
//   o_rec_*                 head record fields (show-ahead)
//   o_level                 occupied entries, 0..DEPTH
//   o_lossy                 high while records are being dropped
//   o_drop_count            drops since the last marker (saturating)
// ---------------------------------------------------------------------------
module rv_retire_fifo #(
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_retire_valid,
  input  logic [29:0]   i_retire_pc,
  input  logic [31:0]   i_retire_instr,
  input  logic          i_retire_reg_write,
  input  logic [4:0]    i_retire_rd,
  input  logic [31:0]   i_retire_reg_data,
  input  logic          i_retire_mem_read,
  input  logic          i_retire_mem_write,
  input  logic [31:0]   i_retire_mem_addr,
  input  logic [3:0]    i_retire_mem_sel,
  input  logic [31:0]   i_retire_mem_data,
  output logic          o_rec_valid,
  input  logic          i_rec_ready,
  output logic          o_rec_drop,
  output logic [29:0]   o_rec_pc,
  output logic [31:0]   o_rec_instr,
  output logic [2:0]    o_rec_flags,
  output logic [4:0]    o_rec_rd,
  output logic [31:0]   o_rec_reg_data,
  output logic [31:0]   o_rec_mem_addr,
  output logic [3:0]    o_rec_mem_sel,
  output logic [31:0]   o_rec_mem_data,
  output logic [LW-1:0] o_level,
  output logic          o_lossy,
  output logic [15:0]   o_drop_count
);

  localparam int AW = LW - 1;
  // drop + pc + instr + flags + rd + reg_data + mem_addr + mem_sel + mem_data
  localparam int RW = 1 + 30 + 32 + 3 + 5 + 32 + 32 + 4 + 32;

  typedef enum logic {ST_NORMAL, ST_LOSSY} state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] mem [DEPTH];
  logic [LW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level;
  logic [15:0]   drop_count_reg, drop_count_next;
  logic [16:0]   drop_sum;
  logic [15:0]   drop_inc;
  logic          full, pop, push, push_marker;
  logic [RW-1:0] instr_rec, marker_rec, push_rec, head_rec;

  // Pointers carry an extra wrap bit, so the difference is the true level
  // and full/empty are never ambiguous.
  assign level = wr_ptr_reg - rd_ptr_reg;
  // Full is taken from the registered level: a pop in the same cycle does
  // not make room for a push.
  assign full        = (level == LW'(DEPTH));
  assign o_rec_valid = (level != '0);
  assign pop         = o_rec_valid && i_rec_ready;

  // Saturating count of the drops so far plus a retire arriving this cycle.
  assign drop_sum = {1'b0, drop_count_reg} + {16'd0, i_retire_valid};
  assign drop_inc = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  assign instr_rec  = {1'b0, i_retire_pc, i_retire_instr,
                       {i_retire_mem_write, i_retire_mem_read, i_retire_reg_write},
                       i_retire_rd, i_retire_reg_data, i_retire_mem_addr,
                       i_retire_mem_sel, i_retire_mem_data};
  // A retire that lands in the marker cycle is itself dropped, so it is
  // included in the count (drop_inc rather than drop_count_reg).
  assign marker_rec = {1'b1, 30'd0, 32'd0, 3'd0, 5'd0, {16'h0, drop_inc},
                       32'd0, 4'd0, 32'd0};
  assign push_rec   = push_marker ? marker_rec : instr_rec;

  // State register, pointers and drop counter.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      state_reg      <= ST_NORMAL;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      drop_count_reg <= drop_count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + LW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + LW'(1);
    end
  end

  // Record storage. A write never targets the head entry while that entry is
  // valid, because a push is only allowed when the buffer is not full.
  always_ff @(posedge i_clk) begin
    if (push && !i_reset && !i_flush)
      mem[wr_ptr_reg[AW-1:0]] <= push_rec;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_NORMAL: if (i_retire_valid && full) state_next = ST_LOSSY;
      ST_LOSSY:  if (!full)                  state_next = ST_NORMAL;
    endcase
  end

  // Output logic: push decisions and drop counter update.
  always_comb begin
    push            = 1'b0;
    push_marker     = 1'b0;
    drop_count_next = drop_count_reg;
    case (state_reg)
      ST_NORMAL: begin
        if (i_retire_valid) begin
          if (!full) push = 1'b1;
          else       drop_count_next = 16'd1;
        end
      end
      ST_LOSSY: begin
        if (full) begin
          drop_count_next = drop_inc;
        end else begin
          push            = 1'b1;
          push_marker     = 1'b1;
          drop_count_next = 16'd0;
        end
      end
    endcase
  end

  // Show-ahead head: outputs come straight from the registered storage.
  assign head_rec = mem[rd_ptr_reg[AW-1:0]];
  assign {o_rec_drop, o_rec_pc, o_rec_instr, o_rec_flags, o_rec_rd,
          o_rec_reg_data, o_rec_mem_addr, o_rec_mem_sel, o_rec_mem_data} = head_rec;

  assign o_level      = level;
  assign o_lossy      = (state_reg == ST_LOSSY);
  assign o_drop_count = drop_count_reg;

endmodule
